// File: rtl/arcade_paddle_ctrl_if.sv
// Player-input and paddle-output bundle between the arcade core and the paddle controller.
// The master drives the raw controls; the slave (controller) returns positions, start and coin.
interface arcade_paddle_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_W       = 8
);
    logic                         vsync;
    logic [2*NUM_PLAYERS-1:0]     mode;
    logic [16*NUM_PLAYERS-1:0]    joy_analog;
    logic [2*NUM_PLAYERS-1:0]     joy_dig;
    logic [10:0]                  ps2_key;
    logic [POS_W*NUM_PLAYERS-1:0] paddle_vpos;
    logic [NUM_PLAYERS-1:0]       start_out;
    logic                         coin_out;

    modport master (
        output vsync, mode, joy_analog, joy_dig, ps2_key,
        input  paddle_vpos, start_out, coin_out
    );

    modport slave (
        input  vsync, mode, joy_analog, joy_dig, ps2_key,
        output paddle_vpos, start_out, coin_out
    );
endinterface

// File: rtl/arcade_paddle_ctrl.sv
// Paddle controller: per-player analog-or-digital paddle position plus start/coin keys
// decoded from a toggle-flagged PS/2 event word.
module arcade_paddle_lane #(
    parameter int POS_W  = 8,
    parameter int STEP   = 4,
    parameter int MAXPOS = 2**POS_W-1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             tick_i,
    input  logic [1:0]       mode_i,
    input  logic [15:0]      joy_i,
    input  logic [1:0]       dig_i,
    output logic [POS_W-1:0] vpos_o
);
    localparam int             SH     = (POS_W < 8) ? 8 - POS_W : 0;
    localparam logic [POS_W:0] MAX_V  = (POS_W+1)'(MAXPOS);
    localparam logic [POS_W:0] STEP_V = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] RST_V = POS_W'(MAXPOS / 2);

    logic [7:0]       mapped;
    logic [POS_W:0]   ana, up_v, dn_v;
    logic [POS_W-1:0] acc_q, acc_d;

    always_comb begin
        case (mode_i)
            2'b00:   mapped = joy_i[15:8] + 8'h80;
            2'b01:   mapped = joy_i[7:0] + 8'h80;
            default: mapped = joy_i[7:0] ^ 8'h7F;
        endcase
        ana  = (POS_W+1)'({2'b00, mapped} >> SH);
        // One spare bit so borrow/overflow is visible and clamps instead of wrapping.
        up_v = {1'b0, acc_q} - STEP_V;
        dn_v = {1'b0, acc_q} + STEP_V;
        acc_d = acc_q;
        if (mode_i != 2'b11) begin
            acc_d = (ana > MAX_V) ? MAX_V[POS_W-1:0] : ana[POS_W-1:0];
        end else if (tick_i) begin
            case (dig_i)
                2'b01:   acc_d = up_v[POS_W] ? '0 : up_v[POS_W-1:0];
                2'b10:   acc_d = (dn_v > MAX_V) ? MAX_V[POS_W-1:0] : dn_v[POS_W-1:0];
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) acc_q <= RST_V;
        else       acc_q <= acc_d;
    end

    assign vpos_o = acc_q;
endmodule

module arcade_paddle_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_W       = 8,
    parameter int STEP        = 4,
    parameter int MAXPOS      = 2**POS_W-1
) (
    input  logic               clk_sys,
    input  logic               reset,
    arcade_paddle_ctrl_if.slave bus
);
    logic                              vsync_q, tog_q, tick, key_ev;
    logic [NUM_PLAYERS-1:0]            start_q, start_d;
    logic [1:0]                        coin_q, coin_d;
    logic [NUM_PLAYERS-1:0][POS_W-1:0] vpos;

    function automatic logic [8:0] start_code(input int p);
        case (p)
            0:       return 9'h016;
            1:       return 9'h01E;
            2:       return 9'h026;
            default: return 9'h025;
        endcase
    endfunction

    always_comb begin
        tick    = bus.vsync & ~vsync_q;
        key_ev  = bus.ps2_key[10] ^ tog_q;
        start_d = start_q;
        coin_d  = coin_q;
        if (key_ev) begin
            for (int p = 0; p < NUM_PLAYERS; p++)
                if (bus.ps2_key[8:0] == start_code(p)) start_d[p] = bus.ps2_key[9];
            if (bus.ps2_key[8:0] == 9'h02E) coin_d[0] = bus.ps2_key[9];
            if (bus.ps2_key[8:0] == 9'h036) coin_d[1] = bus.ps2_key[9];
        end
    end

    // Edge-detect history tracks inputs through reset so release never fires a stale edge.
    always_ff @(posedge clk_sys) begin
        vsync_q <= bus.vsync;
        tog_q   <= bus.ps2_key[10];
        if (reset) begin
            start_q <= '0;
            coin_q  <= '0;
        end else begin
            start_q <= start_d;
            coin_q  <= coin_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        arcade_paddle_lane #(.POS_W(POS_W), .STEP(STEP), .MAXPOS(MAXPOS)) u_lane (
            .clk_sys (clk_sys),
            .reset   (reset),
            .tick_i  (tick),
            .mode_i  (bus.mode[2*p +: 2]),
            .joy_i   (bus.joy_analog[16*p +: 16]),
            .dig_i   (bus.joy_dig[2*p +: 2]),
            .vpos_o  (vpos[p])
        );
    end

    assign bus.paddle_vpos = vpos;
    assign bus.start_out   = start_q;
    assign bus.coin_out    = |coin_q;
endmodule
